// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned requests to instruction memory,
// tracks them with an epoch tag so redirects can squash stale responses, and buffers results for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        err
);

  localparam logic [2:0] CAP = 3'(DEPTH);

  // Handshake rule for every valid/ready pair here: a transfer happens on the rising
  // edge where both are high; a producer holds valid and payload until that edge.

  logic [31:0] pc;
  logic        epoch;

  logic [31:0] inf_addr [2];
  logic        inf_ep   [2];
  logic [1:0]  inf_cnt;

  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic [1:0]  fifo_cnt;

  logic        err_q;
  logic [2:0]  occupancy;
  logic        head_leaves;
  logic        req_fire;
  logic        resp_take;
  logic        fifo_push;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  assign occupancy   = {1'b0, inf_cnt} + {1'b0, fifo_cnt};
  assign out_valid   = (fifo_cnt != 2'd0);
  assign out_pc      = fifo_pc[0];
  assign out_instr   = fifo_instr[0];
  assign err         = err_q;
  assign head_leaves = out_valid && out_ready;

  // A slot freed by the FIFO head leaving this cycle may be reused at once,
  // which is what sustains one instruction per cycle with single-cycle memory.
  assign imem_req_valid = !rst && !redirect_valid &&
                          ((occupancy < CAP) || ((occupancy == CAP) && head_leaves));
  assign imem_req_addr  = pc;

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign resp_take = imem_resp_valid && (inf_cnt != 2'd0);
  assign fifo_push = resp_take && (inf_ep[0] == epoch) && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      epoch <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (imem_resp_valid && (inf_cnt == 2'd0)) begin
        err_q <= 1'b1;
      end
      if (redirect_valid) begin
        pc    <= {redirect_pc[31:2], 2'b00};
        epoch <= ~epoch;
      end else if (req_fire) begin
        pc <= pc + 32'd4;
      end
    end
  end

  // In-flight tracker: slot 0 is the oldest outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inf_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        inf_addr[i] <= 32'd0;
        inf_ep[i]   <= 1'b0;
      end
    end else begin
      case ({req_fire, resp_take})
        2'b10: begin
          inf_addr[inf_cnt[0]] <= pc;
          inf_ep[inf_cnt[0]]   <= epoch;
          inf_cnt              <= inf_cnt + 2'd1;
        end
        2'b01: begin
          inf_addr[0] <= inf_addr[1];
          inf_ep[0]   <= inf_ep[1];
          inf_cnt     <= inf_cnt - 2'd1;
        end
        2'b11: begin
          if (inf_cnt == 2'd1) begin
            inf_addr[0] <= pc;
            inf_ep[0]   <= epoch;
          end else begin
            inf_addr[0] <= inf_addr[1];
            inf_ep[0]   <= inf_ep[1];
            inf_addr[1] <= pc;
            inf_ep[1]   <= epoch;
          end
        end
        default: ;
      endcase
    end
  end

  // Output buffer: slot 0 is the head presented to decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]    <= 32'd0;
        fifo_instr[i] <= 32'd0;
      end
    end else if (redirect_valid) begin
      fifo_cnt <= 2'd0;
    end else begin
      case ({fifo_push, head_leaves})
        2'b10: begin
          fifo_pc[fifo_cnt[0]]    <= inf_addr[0];
          fifo_instr[fifo_cnt[0]] <= imem_resp_data;
          fifo_cnt                <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          fifo_pc[0]    <= fifo_pc[1];
          fifo_instr[0] <= fifo_instr[1];
          fifo_cnt      <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            fifo_pc[0]    <= inf_addr[0];
            fifo_instr[0] <= imem_resp_data;
          end else begin
            fifo_pc[0]    <= fifo_pc[1];
            fifo_instr[0] <= fifo_instr[1];
            fifo_pc[1]    <= inf_addr[0];
            fifo_instr[1] <= imem_resp_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small in-order memory model with configurable latency
// feeds two instances (default reset PC and a wrapping reset PC); scenario tasks check inline.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_ready = 1'b0;

  logic        imem_req_valid, out_valid, err;
  logic [31:0] imem_req_addr, out_pc, out_instr;
  logic        w_imem_req_valid, w_out_valid, w_err;
  logic [31:0] w_imem_req_addr, w_out_pc, w_out_instr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mem_lat = 1;
  int force_cyc = -1;
  logic [31:0] force_data = 32'd0;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] hs_q[$];
  logic [31:0] obs_pc[$];
  logic [31:0] obs_instr[$];
  int          obs_cyc[$];
  logic [31:0] w_obs_pc[$];
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .err(err)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(w_imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_pc(w_out_pc), .out_instr(w_out_instr),
    .err(w_err)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model and output monitor; works mid-cycle, after the scenario drives at negedge.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    forever begin
      @(negedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
      end
      if (force_cyc == cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = force_data;
      end else if (!rst && pend_due.size() != 0 && pend_due[0] <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = ~pend_addr[0];
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      #1;
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + mem_lat);
        hs_q.push_back(imem_req_addr);
      end
      if (out_valid && out_ready && !redirect_valid) begin
        obs_pc.push_back(out_pc);
        obs_instr.push_back(out_instr);
        obs_cyc.push_back(cyc);
      end
      if (w_out_valid && out_ready && !redirect_valid) w_obs_pc.push_back(w_out_pc);
    end
  end

  // Driver tasks
  task automatic clear_logs();
    hs_q.delete();
    obs_pc.delete();
    obs_instr.delete();
    obs_cyc.delete();
    w_obs_pc.delete();
  endtask

  // Returns at the negedge of the first cycle after reset release.
  task automatic do_reset(input int lat, input logic o_rdy, input logic m_rdy);
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    mem_lat = lat;
    out_ready = o_rdy;
    imem_req_ready = m_rdy;
    repeat (2) @(negedge clk);
    clear_logs();
    rst = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    force_data = 32'h1234_5678;
    force_cyc = cyc;
    #4;
    n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_tests++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
    n_tests++; if (out_instr !== 32'd0) begin n_fail++; $display("FAIL reset_out_instr got %h exp 0", out_instr); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
    n_tests++; if (imem_req_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", imem_req_addr); end
    n_tests++; if (w_imem_req_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL reset_wrap_addr got %h exp fffffff8", w_imem_req_addr); end
    @(negedge clk);
    mem_lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    clear_logs();
    rst = 1'b0;
    #4;
    n_tests++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid got %b exp 1", imem_req_valid); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL resp_in_reset_err got %b exp 0", err); end
  endtask

  task automatic test_stream();
    do_reset(1, 1'b1, 1'b1);
    #4;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid_c0 got %b exp 0", out_valid); end
    @(negedge clk); #4;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid_c1 got %b exp 0", out_valid); end
    @(negedge clk); #4;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid_c2 got %b exp 1", out_valid); end
    n_tests++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL stream_first_pc got %h exp 0", out_pc); end
    repeat (4) @(negedge clk);
    #4;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    n_tests++; if (obs_pc.size() < 4) begin n_fail++; $display("FAIL stream_count got %0d exp >=4", obs_pc.size()); end
    n_tests++; if (w_obs_pc.size() < 3) begin n_fail++; $display("FAIL wrap_count got %0d exp >=3", w_obs_pc.size()); end
    if (obs_pc.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        n_tests++; if (obs_pc[i] !== exp_q[i]) begin n_fail++; $display("FAIL stream_pc[%0d] got %h exp %h", i, obs_pc[i], exp_q[i]); end
        n_tests++; if (obs_instr[i] !== ~exp_q[i]) begin n_fail++; $display("FAIL stream_instr[%0d] got %h exp %h", i, obs_instr[i], ~exp_q[i]); end
        n_tests++; if (obs_cyc[i] !== obs_cyc[0] + i) begin n_fail++; $display("FAIL stream_cycle[%0d] got %0d exp %0d", i, obs_cyc[i], obs_cyc[0] + i); end
      end
    end
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    if (w_obs_pc.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        n_tests++; if (w_obs_pc[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_pc[%0d] got %h exp %h", i, w_obs_pc[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #4;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b exp 1", i, out_valid); end
      n_tests++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL bp_pc[%0d] got %h exp 0", i, out_pc); end
      n_tests++; if (out_instr !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL bp_instr[%0d] got %h exp ffffffff", i, out_instr); end
      @(negedge clk);
    end
    #4;
    n_tests++; if (hs_q.size() != 2) begin n_fail++; $display("FAIL bp_requests got %0d exp 2", hs_q.size()); end
    n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid got %b exp 0", imem_req_valid); end
    @(negedge clk);
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    #4;
    n_tests++; if (obs_pc.size() < 6) begin n_fail++; $display("FAIL bp_drain_count got %0d exp >=6", obs_pc.size()); end
    if (obs_pc.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        n_tests++; if (obs_pc[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL bp_drain_pc[%0d] got %h exp %h", i, obs_pc[i], 32'(4 * i)); end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(3, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    #4;
    n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_req_valid got %b exp 0", imem_req_valid); end
    n_tests++; if (hs_q.size() != 2) begin n_fail++; $display("FAIL redir_inflight got %0d exp 2", hs_q.size()); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #4;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_out_valid got %b exp 0", out_valid); end
    n_tests++; if (imem_req_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL redir_addr got %h exp 00000100", imem_req_addr); end
    repeat (10) @(negedge clk);
    #4;
    n_tests++; if (obs_pc.size() < 2) begin n_fail++; $display("FAIL redir_count got %0d exp >=2", obs_pc.size()); end
    if (obs_pc.size() >= 2) begin
      n_tests++; if (obs_pc[0] !== 32'h0000_0100) begin n_fail++; $display("FAIL redir_pc0 got %h exp 00000100", obs_pc[0]); end
      n_tests++; if (obs_instr[0] !== ~32'h0000_0100) begin n_fail++; $display("FAIL redir_instr0 got %h exp %h", obs_instr[0], ~32'h0000_0100); end
      n_tests++; if (obs_pc[1] !== 32'h0000_0104) begin n_fail++; $display("FAIL redir_pc1 got %h exp 00000104", obs_pc[1]); end
    end
  endtask

  task automatic test_err();
    do_reset(1, 1'b1, 1'b0);
    #4;
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_before got %b exp 0", err); end
    @(negedge clk);
    force_data = 32'hDEAD_BEEF;
    force_cyc = cyc;
    @(negedge clk); #4;
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b exp 1", err); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err_no_write got %b exp 0", out_valid); end
    repeat (3) @(negedge clk);
    #4;
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", err); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err_no_write_late got %b exp 0", out_valid); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_async_clear got %b exp 0", err); end
    n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL err_rst_req_valid got %b exp 0", imem_req_valid); end
  endtask

  task automatic test_mid_reset();
    do_reset(1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    #4;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_filled got %b exp 1", out_valid); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %b exp 0", out_valid); end
    n_tests++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL mid_out_pc got %h exp 0", out_pc); end
    @(negedge clk);
    clear_logs();
    out_ready = 1'b1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #4;
    n_tests++; if (obs_pc.size() < 2) begin n_fail++; $display("FAIL mid_count got %0d exp >=2", obs_pc.size()); end
    if (obs_pc.size() >= 2) begin
      n_tests++; if (obs_pc[0] !== 32'd0) begin n_fail++; $display("FAIL mid_pc0 got %h exp 0", obs_pc[0]); end
      n_tests++; if (obs_pc[1] !== 32'd4) begin n_fail++; $display("FAIL mid_pc1 got %h exp 4", obs_pc[1]); end
    end
  endtask

  task automatic test_stall();
    do_reset(1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #4;
      n_tests++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b exp 1", i, imem_req_valid); end
      n_tests++; if (imem_req_addr !== 32'd0) begin n_fail++; $display("FAIL stall_addr[%0d] got %h exp 0", i, imem_req_addr); end
      @(negedge clk);
    end
    imem_req_ready = 1'b1;
    repeat (6) @(negedge clk);
    #4;
    n_tests++; if (hs_q.size() < 3) begin n_fail++; $display("FAIL stall_req_count got %0d exp >=3", hs_q.size()); end
    if (hs_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        n_tests++; if (hs_q[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL stall_req[%0d] got %h exp %h", i, hs_q[i], 32'(4 * i)); end
      end
    end
    n_tests++; if (obs_pc.size() < 2) begin n_fail++; $display("FAIL stall_out_count got %0d exp >=2", obs_pc.size()); end
    if (obs_pc.size() >= 2) begin
      n_tests++; if (obs_pc[0] !== 32'd0) begin n_fail++; $display("FAIL stall_pc0 got %h exp 0", obs_pc[0]); end
      n_tests++; if (obs_pc[1] !== 32'd4) begin n_fail++; $display("FAIL stall_pc1 got %h exp 4", obs_pc[1]); end
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_err();
    test_mid_reset();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, fixed at 2, combined limit on in-flight requests plus buffered instructions.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-006 SHALL have port imem_req_ready, input, 1, memory accepts request.
REQ-007 SHALL have port imem_req_addr, output, 32, word-aligned fetch address.
REQ-008 SHALL have port imem_resp_valid, input, 1, one in-order response per accepted request, at least 1 cycle after acceptance.
REQ-009 SHALL have port imem_resp_data, input, 32, instruction word.
REQ-010 SHALL have port redirect_valid, input, 1, branch/jump redirect from execute.
REQ-011 SHALL have port redirect_pc, input, 32, redirect target; bits[1:0] ignored and treated as 0.
REQ-012 SHALL have port out_valid, output, 1, instruction available to decode.
REQ-013 SHALL have port out_ready, input, 1, decode accepts instruction.
REQ-014 SHALL have port out_pc, output, 32, address of out_instr.
REQ-015 SHALL have port out_instr, output, 32, instruction word.
REQ-016 SHALL have port err, output, 1, sticky protocol error flag.

Function
REQ-017 SHALL hold fetch PC, 2-entry in-flight queue of {addr, epoch}, 2-entry output FIFO of {pc, instr}, 1-bit epoch.
REQ-018 SHALL drive imem_req_valid=1 iff inflight_count + fifo_count < 2 and redirect_valid=0; imem_req_addr = PC.
REQ-019 SHALL, once imem_req_valid=1, hold it and imem_req_addr stable until accepted, except when redirect_valid forces them off.
REQ-020 SHALL, on request handshake, push {PC, epoch} into in-flight queue and set PC <= PC+4, wrapping 32'hFFFF_FFFC -> 32'h0.
REQ-021 SHALL, on imem_resp_valid, pop in-flight queue; if popped epoch equals current epoch, push {addr, imem_resp_data} into FIFO, else discard.
REQ-022 SHALL set err=1 (sticky until reset) on imem_resp_valid with inflight_count=0, and ignore that response.
REQ-023 SHALL drive out_valid = FIFO non-empty, out_pc/out_instr = FIFO head, combinationally from registers; head SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 SHALL pop FIFO on out_valid and out_ready; push and pop in the same cycle SHALL both take effect.
REQ-025 SHALL, on redirect_valid=1: PC <= {redirect_pc[31:2],2'b00}, epoch toggles, FIFO flushed (out_valid=0 next cycle), no request issued that cycle; in-flight entries kept so their responses are later discarded.
REQ-026 SHALL give redirect priority: a response arriving in the redirect cycle is compared against the pre-toggle epoch and SHALL NOT be written to the FIFO; a same-cycle output pop has no further effect.
REQ-027 SHALL achieve steady-state throughput of 1 instruction/cycle with 1-cycle memory latency and out_ready=1.
REQ-028 SHALL reach out_valid=1 at earliest 2 cycles after the request handshake (response cycle + FIFO write).

Reset
REQ-029 SHALL, while rst=1, asynchronously set PC=RESET_PC, epoch=0, queues empty, imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0, err=0.
REQ-030 SHALL discard any response arriving during reset; first request issues in first cycle after rst deasserts.
REQ-031 SHALL, on reset mid-operation, drop all in-flight and buffered state without emitting partial instructions.

Verification
REQ-032 Reset release, imem_req_ready=1, 1-cycle response latency, out_ready=1 -> out_pc sequence 0,4,8,12 on consecutive cycles, out_valid first high 2 cycles after rst low.
REQ-033 out_ready=0 for 5 cycles -> at most 2 requests outstanding/buffered, imem_req_valid=0 afterward, out_pc/out_instr stable; release -> no loss or duplication.
REQ-034 Redirect to 32'h0000_0103 with 2 requests in flight -> both responses discarded, next out_pc=32'h0000_0100, out_valid=0 the cycle after redirect.
REQ-035 imem_resp_valid pulse with nothing in flight -> err=1 and stays 1, no FIFO write, until rst.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 imem_req_ready=0 for 3 cycles then 1 -> imem_req_addr constant during stall, single request per address.
